// File: rtl/max_pool_controller_if.sv
// Bundles the buffer-read, pooling-engine and result-stream signals of one
// max_pool_controller. "master" is the controller side, "slave" is the
// environment (buffer, engine, downstream consumer, job issuer).
interface max_pool_controller_if #(
  parameter int IL     = 4,
  parameter int FL     = 16,
  parameter int size   = 4,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 8
);
  localparam int DW = IL + FL;

  // job control
  logic                      start;
  logic [ADDR_W-1:0]         base_addr;
  logic [CNT_W-1:0]          num_win;
  logic                      busy;
  logic                      job_done;
  // scratch buffer read port
  logic                      rd_en;
  logic [ADDR_W-1:0]         rd_addr;
  logic [DW-1:0]             rd_data;
  // pooling engine
  logic                      pool_en;
  logic                      pool_input_ready;
  logic [size-1:0][DW-1:0]   pool_im;
  logic [DW-1:0]             pool_om;
  logic                      pool_done;
  // result stream
  logic                      out_valid;
  logic                      out_ready;
  logic [DW-1:0]             out_data;
  logic [CNT_W-1:0]          out_idx;

  modport master (
    input  start, base_addr, num_win, rd_data, pool_om, pool_done, out_ready,
    output busy, job_done, rd_en, rd_addr, pool_en, pool_input_ready, pool_im,
           out_valid, out_data, out_idx
  );

  modport slave (
    output start, base_addr, num_win, rd_data, pool_om, pool_done, out_ready,
    input  busy, job_done, rd_en, rd_addr, pool_en, pool_input_ready, pool_im,
           out_valid, out_data, out_idx
  );
endinterface

// File: rtl/max_pool_controller.sv
// Sequencer for one max_pooling engine: fetches NUM_WIN windows of `size`
// contiguous buffer words into a local register file, runs the engine over
// each window and streams the window maxima out on a valid/ready port.
module max_pool_controller #(
  parameter int IL     = 4,
  parameter int FL     = 16,
  parameter int size   = 4,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  max_pool_controller_if.master bus
);
  localparam int DW    = IL + FL;
  localparam int width = $clog2(size);
  localparam logic [width-1:0] K_LAST = width'(size - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_RUN,
    S_CAPT,
    S_OUT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  nwin_q, nwin_d;
  logic [CNT_W-1:0]  win_q, win_d;
  logic [width-1:0]  k_q, k_d;
  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_idx_q, out_idx_d;
  logic              job_done_q, job_done_d;

  // read data lags rd_en by one cycle, so the slot index travels with it
  logic              cap_vld_q;
  logic [width-1:0]  cap_slot_q;

  logic              rd_en_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [ADDR_W-1:0] win_offs;
  logic              pool_en_c;
  logic              pool_ir_c;

  // size is a power of two, so win*size+k is just {win, k}; the sum wraps mod 2^ADDR_W
  assign win_offs  = ADDR_W'({win_q, k_q});
  assign rd_addr_c = rd_en_c ? (base_q + win_offs) : '0;

  // next-state and per-state outputs
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    nwin_d      = nwin_q;
    win_d       = win_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    job_done_d  = 1'b0;
    rd_en_c     = 1'b0;
    pool_en_c   = 1'b0;
    pool_ir_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d = bus.base_addr;
          nwin_d = bus.num_win;
          win_d  = '0;
          k_d    = '0;
          if (bus.num_win == '0) begin
            job_done_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        rd_en_c = 1'b1;
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // clears the engine's running max and pointer for this window
        pool_en_c = 1'b1;
        pool_ir_c = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        pool_en_c = 1'b1;
        if (bus.pool_done) begin
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        out_data_d  = bus.pool_om;
        out_idx_d   = win_q;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (win_q == nwin_q - 1'b1) begin
            job_done_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            win_d   = win_q + 1'b1;
            k_d     = '0;
            state_d = S_FETCH;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // control and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      nwin_q      <= '0;
      win_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      job_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      nwin_q      <= nwin_d;
      win_q       <= win_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      job_done_q  <= job_done_d;
    end
  end

  // delay the fetch slot to line up with the returning read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_vld_q  <= 1'b0;
      cap_slot_q <= '0;
    end else begin
      cap_vld_q  <= rd_en_c;
      cap_slot_q <= k_q;
    end
  end

  generate
    for (genvar gi = 0; gi < size; gi++) begin : g_slot
      localparam logic [width-1:0] SLOT = width'(gi);
      logic [DW-1:0] slot_q;

      // window register: loads when its delayed fetch slot returns
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_q <= '0;
        end else if (cap_vld_q && (cap_slot_q == SLOT)) begin
          slot_q <= bus.rd_data;
        end
      end

      assign bus.pool_im[gi] = slot_q;
    end
  endgenerate

  assign bus.rd_en            = rd_en_c;
  assign bus.rd_addr          = rd_addr_c;
  assign bus.pool_en          = pool_en_c;
  assign bus.pool_input_ready = pool_ir_c;
  assign bus.out_valid        = out_valid_q;
  assign bus.out_data         = out_data_q;
  assign bus.out_idx          = out_idx_q;
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.job_done         = job_done_q;
endmodule
